// File: rtl/sign_extend.sv
// Immediate extension unit: widens a 16-bit immediate to 32 bits.
// Combinational result plus a registered copy with a valid flag.
module sign_extend (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [1:0]  ext_op,
    input  logic        en,
    output logic [31:0] y,
    output logic [31:0] y_q,
    output logic        valid_q
);

    localparam logic [1:0] OP_SIGN   = 2'b00;
    localparam logic [1:0] OP_ZERO   = 2'b01;
    localparam logic [1:0] OP_UPPER  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    logic [31:0] y_q_d;
    logic        valid_q_d;

    // Select the extension form from ext_op.
    always_comb begin
        y = {{16{a[15]}}, a};
        unique case (ext_op)
            OP_SIGN:   y = {{16{a[15]}}, a};
            OP_ZERO:   y = {16'h0000, a};
            OP_UPPER:  y = {a, 16'h0000};
            OP_BRANCH: y = {{14{a[15]}}, a, 2'b00};
            default:   y = {{16{a[15]}}, a};
        endcase
    end

    // Load the registered copy when enabled, otherwise hold.
    always_comb begin
        y_q_d     = y_q;
        valid_q_d = valid_q;
        if (en) begin
            y_q_d     = y;
            valid_q_d = 1'b1;
        end
    end

    // Registered outputs; reset clears them and wins over en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_q_d;
            valid_q <= valid_q_d;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: directed boundary vectors,
// register/reset checks and randomized traffic against a reference.
module tb_sign_extend;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a = '0;
    logic [1:0]  ext_op = '0;
    logic        en = 1'b0;
    logic [31:0] y;
    logic [31:0] y_q;
    logic        valid_q;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] y;
        logic [31:0] yq;
        logic        v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_yq = '0;
    logic        m_v = 1'b0;

    sign_extend dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .ext_op(ext_op),
        .en(en),
        .y(y),
        .y_q(y_q),
        .valid_q(valid_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_y(logic [15:0] av, logic [1:0] op);
        int s;
        s = int'($signed(av));
        case (op)
            2'd0:    return 32'(s);
            2'd1:    return 32'(av);
            2'd2:    return 32'(av) * 32'h0001_0000;
            default: return 32'(s * 4);
        endcase
    endfunction

    // One cycle: inputs applied just after the rising edge, checked at
    // the following falling edge by the monitor.
    task automatic step(input logic [15:0] av, input logic [1:0] op,
                        input logic ev, input logic rv,
                        input bit use_lit, input logic [31:0] lit,
                        input string tag);
        exp_t e;
        logic [31:0] ry;
        @(posedge clk);
        #1;
        a = av;
        ext_op = op;
        en = ev;
        rst = rv;
        ry = ref_y(av, op);
        e.y = use_lit ? lit : ry;
        e.yq = rv ? 32'h0 : m_yq;
        e.v = rv ? 1'b0 : m_v;
        e.tag = tag;
        sb.push_back(e);
        if (rv) begin
            m_yq = '0;
            m_v = 1'b0;
        end else if (ev) begin
            m_yq = ry;
            m_v = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (y !== e.y || $isunknown(y)) begin
                bad++;
                $display("FAIL %s y: got %h want %h", e.tag, y, e.y);
            end
            total++;
            if (y_q !== e.yq) begin
                bad++;
                $display("FAIL %s y_q: got %h want %h", e.tag, y_q, e.yq);
            end
            total++;
            if (valid_q !== e.v) begin
                bad++;
                $display("FAIL %s valid_q: got %b want %b", e.tag, valid_q, e.v);
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [1:0]  rop;
        logic        ren;
        logic        rrs;
        step(16'h0000, 2'b00, 1'b0, 1'b1, 1, 32'h0000_0000, "reset0");
        step(16'h1111, 2'b00, 1'b0, 1'b1, 1, 32'h0000_1111, "reset1");
        step(16'h0000, 2'b00, 1'b0, 1'b0, 1, 32'h0000_0000, "s0000");
        step(16'h0001, 2'b00, 1'b0, 1'b0, 1, 32'h0000_0001, "s0001");
        step(16'h7FFF, 2'b00, 1'b0, 1'b0, 1, 32'h0000_7FFF, "s7FFF");
        step(16'h8000, 2'b00, 1'b0, 1'b0, 1, 32'hFFFF_8000, "s8000");
        step(16'hFFFF, 2'b00, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, "sFFFF");
        step(16'h1234, 2'b00, 1'b0, 1'b0, 1, 32'h0000_1234, "s1234");
        step(16'hABCD, 2'b00, 1'b0, 1'b0, 1, 32'hFFFF_ABCD, "sABCD");
        step(16'hF00F, 2'b01, 1'b0, 1'b0, 1, 32'h0000_F00F, "zero");
        step(16'hF00F, 2'b10, 1'b0, 1'b0, 1, 32'hF00F_0000, "upper");
        step(16'hF00F, 2'b11, 1'b0, 1'b0, 1, 32'hFFFF_C03C, "branch");
        step(16'h7FFF, 2'b11, 1'b0, 1'b0, 1, 32'h0001_FFFC, "br7FFF");
        step(16'h8000, 2'b11, 1'b0, 1'b0, 1, 32'hFFFE_0000, "br8000");
        step(16'h8001, 2'b00, 1'b1, 1'b0, 1, 32'hFFFF_8001, "load");
        step(16'h0002, 2'b00, 1'b0, 1'b0, 1, 32'h0000_0002, "hold1");
        step(16'h0003, 2'b01, 1'b0, 1'b0, 1, 32'h0000_0003, "hold2");
        step(16'h8765, 2'b00, 1'b0, 1'b1, 1, 32'hFFFF_8765, "async");
        step(16'h1234, 2'b00, 1'b1, 1'b1, 1, 32'h0000_1234, "prio");
        step(16'h4321, 2'b10, 1'b0, 1'b0, 1, 32'h4321_0000, "after");
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rop = 2'($urandom_range(0, 3));
            ren = 1'($urandom_range(0, 1));
            rrs = ($urandom_range(0, 19) == 0);
            step(ra, rop, ren, rrs, 0, 32'h0, "rand");
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
